// File: rtl/ctr_pr_timer_pkg.sv
// rtl/ctr_pr_timer_pkg.sv - shared ctr_pr definitions: tap masks, seed, FSM encodings
package ctr_pr_timer_pkg;

  // FSM encodings shared by the ctr_pr family
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // All-zeros seed; with XNOR feedback the all-ones word is the lockup state
  localparam logic [7:0] SEED_BITS = 8'h00;

  // Tap mask per LFSR width, bit i set means 1-based tap i+1 feeds back
  function automatic logic [7:0] tap_mask(input int width);
    case (width)
      4:       tap_mask = 8'b0000_1100;
      5:       tap_mask = 8'b0001_0100;
      6:       tap_mask = 8'b0011_0000;
      default: tap_mask = 8'b0110_0000;
    endcase
  endfunction

endpackage

// File: rtl/ctr_pr_next.sv
// rtl/ctr_pr_next.sv - combinational Fibonacci LFSR next-state (shift left, XNOR into bit 0)
module ctr_pr_next
  import ctr_pr_timer_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [7:0]       MASK_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] MASK      = MASK_FULL[WIDTH-1:0];

  logic fb;

  // XNOR of the tapped bits shifts in at the bottom
  always_comb begin
    fb  = ~^(cur & MASK);
    nxt = {cur[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/ctr_pr_timer.sv
// rtl/ctr_pr_timer.sv - LFSR periodic tick generator; optional CTR_PR_TIMER_ONESHOT_EN adds oneshot input
module ctr_pr_timer
  import ctr_pr_timer_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic             inc,
`ifdef CTR_PR_TIMER_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic             busy,
  output logic             tick,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] SEED = SEED_BITS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] run_q;
  logic             tick_q;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] run_nxt;
  logic             stop_at_match;

`ifdef CTR_PR_TIMER_ONESHOT_EN
  assign stop_at_match = oneshot;
`else
  assign stop_at_match = 1'b0;
`endif

  // Shadow walks p-1 steps from the seed to find the terminal state
  ctr_pr_next #(.WIDTH(WIDTH)) u_next_shadow (
    .cur (shadow),
    .nxt (shadow_nxt)
  );

  // Run register steps once per accepted inc
  ctr_pr_next #(.WIDTH(WIDTH)) u_next_run (
    .cur (run_q),
    .nxt (run_nxt)
  );

  // Conversion, run and reload sequencing; load always wins over inc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shadow   <= ZERO;
      terminal <= ZERO;
      cnt      <= ZERO;
      run_q    <= ZERO;
      tick_q   <= 1'b0;
    end else if (load) begin
      tick_q <= 1'b0;
      run_q  <= SEED;
      if (period == ZERO) begin
        state <= ST_IDLE;
      end else begin
        shadow <= SEED;
        cnt    <= period - ONE;
        state  <= ST_CONV;
      end
    end else begin
      case (state)
        ST_CONV: begin
          tick_q <= 1'b0;
          if (cnt == ZERO) begin
            terminal <= shadow;
            state    <= ST_RUN;
          end else begin
            shadow <= shadow_nxt;
            cnt    <= cnt - ONE;
          end
        end
        ST_RUN: begin
          if (inc) begin
            if (run_q == terminal) begin
              run_q  <= SEED;
              tick_q <= 1'b1;
              if (stop_at_match) begin
                state <= ST_IDLE;
              end
            end else begin
              run_q  <= run_nxt;
              tick_q <= 1'b0;
            end
          end else begin
            tick_q <= 1'b0;
          end
        end
        default: begin
          tick_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_CONV);
  assign tick = tick_q;
  assign out  = run_q;

endmodule

// File: tb/tb_ctr_pr_timer.sv
// tb/tb_ctr_pr_timer.sv - randomized self-checking bench for ctr_pr_timer (WIDTH=4)
module tb_ctr_pr_timer;

  localparam int W = 4;
  localparam int P = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] period;
  logic         inc;
`ifdef CTR_PR_TIMER_ONESHOT_EN
  logic         oneshot;
`endif
  logic         busy;
  logic         tick;
  logic [W-1:0] out;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] seq [0:P-1];
  int   m_mode;
  int   m_left;
  int   m_idx;
  int   m_p;
  logic m_tick;

  ctr_pr_timer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .period  (period),
    .inc     (inc),
`ifdef CTR_PR_TIMER_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .busy    (busy),
    .tick    (tick),
    .out     (out)
  );

  always #5 clk = ~clk;

  function automatic void build_seq();
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < P; i++) begin
      seq[i] = s;
      s = {s[W-2:0], ~(s[3] ^ s[2])};
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_idx = 0; m_p = 1; m_tick = 1'b0;
  endfunction

  // Reference: period position counter; out is the idx-th state from the seed
  task automatic step(input logic ld, input logic [W-1:0] p, input logic in_inc);
    load = ld; period = p; inc = in_inc;
    if (ld) begin
      m_tick = 1'b0; m_idx = 0;
      if (p == 0) m_mode = 0;
      else begin m_mode = 1; m_left = int'(p); m_p = int'(p); end
    end else if (m_mode == 1) begin
      m_tick = 1'b0; m_left--;
      if (m_left == 0) m_mode = 2;
    end else if (m_mode == 2) begin
      if (in_inc) begin
        if (m_idx == m_p - 1) begin
          m_idx = 0; m_tick = 1'b1;
`ifdef CTR_PR_TIMER_ONESHOT_EN
          if (oneshot) m_mode = 0;
`endif
        end else begin
          m_idx++; m_tick = 1'b0;
        end
      end else m_tick = 1'b0;
    end else m_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; inc = 1'b0; period = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; model_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", tick); end
      vectors++; if (out !== 4'b0000) begin miscompares++; $display("FAIL reset_out: got %b want 0000", out); end
    end
  endtask

  task automatic test_p5();
    logic [W-1:0] lit [0:4];
    lit[0] = 4'b0001; lit[1] = 4'b0011; lit[2] = 4'b0111; lit[3] = 4'b1110; lit[4] = 4'b0000;
    step(1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL p5_busy[%0d]: got %b want 1", k, busy); end
      step(1'b0, 4'd0, 1'b1);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL p5_busy_end: got %b want 0", busy); end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'd0, 1'b1);
      if (i < 5) begin
        vectors++; if (out !== lit[i]) begin miscompares++; $display("FAIL p5_seq[%0d]: got %b want %b", i, out, lit[i]); end
      end
      vectors++; if (tick !== ((i % 5) == 4)) begin miscompares++; $display("FAIL p5_tick[%0d]: got %b want %b", i, tick, (i % 5) == 4); end
      vectors++; if (out !== seq[m_idx]) begin miscompares++; $display("FAIL p5_out[%0d]: got %b want %b", i, out, seq[m_idx]); end
    end
  endtask

  task automatic test_extremes();
    int ticks;
    int distinct;
    bit seen [0:15];
    step(1'b1, 4'd1, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'd0, 1'b1);
      vectors++; if (tick !== 1'b1 || out !== 4'b0000) begin miscompares++; $display("FAIL p1_tick[%0d]: got tick=%b out=%b want 1/0000", i, tick, out); end
    end
    step(1'b1, 4'd15, 1'b1);
    for (int k = 0; k < 15; k++) step(1'b0, 4'd0, 1'b1);
    ticks = 0;
    for (int per = 0; per < 3; per++) begin
      for (int j = 0; j < 16; j++) seen[j] = 1'b0;
      distinct = 0;
      for (int i = 0; i < 15; i++) begin
        if (!seen[out]) distinct++;
        seen[out] = 1'b1;
        step(1'b0, 4'd0, 1'b1);
        if (tick === 1'b1) ticks++;
        vectors++; if (out !== seq[m_idx] || tick !== m_tick) begin miscompares++; $display("FAIL p15_step: got %b/%b want %b/%b", out, tick, seq[m_idx], m_tick); end
      end
      vectors++; if (distinct != 15 || seen[15]) begin miscompares++; $display("FAIL p15_states: got %0d distinct lockup=%b want 15/0", distinct, seen[15]); end
    end
    vectors++; if (ticks != 3) begin miscompares++; $display("FAIL p15_ticks: got %0d want 3", ticks); end
  endtask

  task automatic test_toggle();
    int last_tick;
    logic [W-1:0] prev;
    step(1'b1, 4'd5, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'd0, 1'b0);
    last_tick = -1;
    for (int i = 0; i < 40; i++) begin
      prev = out;
      step(1'b0, 4'd0, 1'(i % 2 == 0));
      if (i % 2 == 1) begin
        vectors++; if (out !== prev) begin miscompares++; $display("FAIL toggle_hold[%0d]: got %b want %b", i, out, prev); end
      end
      vectors++; if (tick !== m_tick || out !== seq[m_idx]) begin miscompares++; $display("FAIL toggle_step[%0d]: got %b/%b want %b/%b", i, out, tick, seq[m_idx], m_tick); end
      if (tick === 1'b1) begin
        if (last_tick >= 0) begin
          vectors++; if (i - last_tick != 10) begin miscompares++; $display("FAIL toggle_gap: got %0d want 10", i - last_tick); end
        end
        last_tick = i;
      end
    end
  endtask

  task automatic test_reload();
    step(1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 4'd0, 1'b1);
    vectors++; if (out !== 4'b1110) begin miscompares++; $display("FAIL reload_pre: got %b want 1110", out); end
    step(1'b1, 4'd3, 1'b1);
    vectors++; if (tick !== 1'b0 || busy !== 1'b1 || out !== 4'b0000) begin miscompares++; $display("FAIL reload_edge: got t=%b b=%b o=%b want 0/1/0000", tick, busy, out); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 4'd0, 1'b1);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reload_busy[%0d]: got %b want 1", k, busy); end
    end
    step(1'b0, 4'd0, 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reload_busy_end: got %b want 0", busy); end
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    vectors++; if (out !== 4'b0011 || tick !== 1'b0) begin miscompares++; $display("FAIL reload_term: got %b/%b want 0011/0", out, tick); end
    step(1'b0, 4'd0, 1'b1);
    vectors++; if (out !== 4'b0000 || tick !== 1'b1) begin miscompares++; $display("FAIL reload_tick: got %b/%b want 0000/1", out, tick); end
    step(1'b1, 4'd7, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    rst = 1'b1; #1;
    vectors++; if (busy !== 1'b0 || out !== 4'b0000 || tick !== 1'b0) begin miscompares++; $display("FAIL rst_mid_conv: got b=%b o=%b t=%b want 0/0000/0", busy, out, tick); end
    @(posedge clk); #1; rst = 1'b0; model_reset();
    step(1'b0, 4'd0, 1'b1);
    vectors++; if (busy !== 1'b0 || out !== 4'b0000) begin miscompares++; $display("FAIL rst_after: got b=%b o=%b want 0/0000", busy, out); end
  endtask

  task automatic test_oneshot();
    int ticks;
    int want;
`ifdef CTR_PR_TIMER_ONESHOT_EN
    oneshot = 1'b1; want = 1;
`else
    want = 4;
`endif
    ticks = 0;
    step(1'b1, 4'd4, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, 1'b1);
      if (tick === 1'b1) ticks++;
      vectors++; if (out !== seq[m_idx] || tick !== m_tick || busy !== (m_mode == 1)) begin miscompares++; $display("FAIL oneshot_step[%0d]: got %b/%b want %b/%b", i, out, tick, seq[m_idx], m_tick); end
    end
    vectors++; if (ticks != want) begin miscompares++; $display("FAIL oneshot_ticks: got %0d want %0d", ticks, want); end
`ifdef CTR_PR_TIMER_ONESHOT_EN
    oneshot = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
`ifdef CTR_PR_TIMER_ONESHOT_EN
      oneshot = 1'($urandom_range(0, 7) == 0);
`endif
      step(1'($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      vectors++; if (out !== seq[m_idx]) begin miscompares++; $display("FAIL rand_out[%0d]: got %b want %b", i, out, seq[m_idx]); end
      vectors++; if (tick !== m_tick) begin miscompares++; $display("FAIL rand_tick[%0d]: got %b want %b", i, tick, m_tick); end
      vectors++; if (busy !== (m_mode == 1)) begin miscompares++; $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_mode == 1); end
    end
  endtask

  initial begin
    build_seq();
    model_reset();
`ifdef CTR_PR_TIMER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    test_reset();
    test_p5();
    test_extremes();
    test_toggle();
    test_reload();
    test_oneshot();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
